// File: rtl/gpio_access_arbiter.sv
// gpio_access_arbiter: round-robin Avalon-MM master that shares the LED and
// test-point PIO s1 ports between two requesters. It runs one transaction at
// a time and implements bit-set/bit-clear as an atomic read-modify-write.

module gpio_access_arbiter #(
   parameter int unsigned RD_LAT = 1,   // PIO s1 read latency, 1..3
   parameter int unsigned DW     = 32,
   parameter int unsigned AW     = 3
) (
   input  logic          pheriphal_clk_clk,
   input  logic          pheriphal_reset_reset,

   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic          req0_target,
   input  logic [1:0]    req0_op,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_wdata,
   output logic          req0_rvalid,
   output logic [DW-1:0] req0_rdata,

   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic          req1_target,
   input  logic [1:0]    req1_op,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_wdata,
   output logic          req1_rvalid,
   output logic [DW-1:0] req1_rdata,

   output logic [AW-1:0] led_s1_address,
   output logic          led_s1_write_n,
   output logic [DW-1:0] led_s1_writedata,
   output logic          led_s1_chipselect,
   input  logic [DW-1:0] led_s1_readdata,

   output logic [AW-1:0] tp_s1_address,
   output logic          tp_s1_write_n,
   output logic [DW-1:0] tp_s1_writedata,
   output logic          tp_s1_chipselect,
   input  logic [DW-1:0] tp_s1_readdata,

   output logic          busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_WRITE,
      S_RESP
   } state_t;

   typedef enum logic [1:0] {
      OP_RD  = 2'b00,
      OP_WR  = 2'b01,
      OP_SET = 2'b10,
      OP_CLR = 2'b11
   } op_t;

   localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

   logic clk;
   logic rst;

   assign clk = pheriphal_clk_clk;
   assign rst = pheriphal_reset_reset;

   state_t        state;
   state_t        state_nxt;

   // Latched transaction context
   logic          gnt_id_q;     // requester being served
   logic          tgt_q;        // 0 = LED, 1 = TP
   op_t           op_q;
   logic [DW-1:0] mask_q;       // set/clear mask
   logic [DW-1:0] cap_q;        // captured readdata
   logic [1:0]    cnt_q;        // read latency counter
   logic          rr_q;         // requester favoured on a tie

   // Arbitration / datapath helpers
   logic          grant_any;
   logic          grant_id;
   logic          sel_target;
   logic [1:0]    sel_op;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic [DW-1:0] rd_sel;
   logic [DW-1:0] merged;
   logic          capture;
   logic          resp_load;
   logic [DW-1:0] resp_data;

   logic          bus_cs;
   logic          bus_wr;

   // Round-robin arbitration and selection of the granted request fields
   always_comb begin
      grant_any  = (state == S_IDLE) && (req0_valid || req1_valid);
      grant_id   = (req0_valid && req1_valid) ? rr_q : req1_valid;
      sel_target = grant_id ? req1_target : req0_target;
      sel_op     = grant_id ? req1_op     : req0_op;
      sel_addr   = grant_id ? req1_addr   : req0_addr;
      sel_wdata  = grant_id ? req1_wdata  : req0_wdata;
   end

   // Read-data capture and read-modify-write merge
   always_comb begin
      rd_sel  = tgt_q ? tp_s1_readdata : led_s1_readdata;
      capture = (state == S_WAIT) && (cnt_q == 2'd1);
      if (op_q == OP_SET) begin
         merged = rd_sel | mask_q;
      end else begin
         merged = rd_sel & ~mask_q;
      end
   end

   // Response data is loaded on the cycle that enters RESP
   always_comb begin
      resp_load = 1'b0;
      resp_data = '0;
      if ((state == S_ISSUE) && (op_q == OP_WR)) begin
         resp_load = 1'b1;
         resp_data = '0;
      end else if (capture && (op_q == OP_RD)) begin
         resp_load = 1'b1;
         resp_data = rd_sel;
      end else if (state == S_WRITE) begin
         resp_load = 1'b1;
         resp_data = cap_q;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (grant_any) begin
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_nxt = (op_q == OP_WR) ? S_RESP : S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == 2'd1) begin
               state_nxt = (op_q == OP_RD) ? S_RESP : S_WRITE;
            end
         end
         S_WRITE: begin
            state_nxt = S_RESP;
         end
         S_RESP: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // FSM outputs: handshakes, strobes and busy decoded from the current state
   always_comb begin
      bus_cs            = (state == S_ISSUE) || (state == S_WRITE);
      bus_wr            = ((state == S_ISSUE) && (op_q == OP_WR)) || (state == S_WRITE);
      req0_ready        = grant_any && !grant_id;
      req1_ready        = grant_any &&  grant_id;
      req0_rvalid       = (state == S_RESP) && !gnt_id_q;
      req1_rvalid       = (state == S_RESP) &&  gnt_id_q;
      led_s1_chipselect = bus_cs && !tgt_q;
      tp_s1_chipselect  = bus_cs &&  tgt_q;
      led_s1_write_n    = !(led_s1_chipselect && bus_wr);
      tp_s1_write_n     = !(tp_s1_chipselect  && bus_wr);
      busy              = (state != S_IDLE);
   end

   // Latch the granted request and advance the round-robin pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_id_q <= 1'b0;
         tgt_q    <= 1'b0;
         op_q     <= OP_RD;
         mask_q   <= '0;
         rr_q     <= 1'b0;
      end else if (grant_any) begin
         gnt_id_q <= grant_id;
         tgt_q    <= sel_target;
         op_q     <= op_t'(sel_op);
         mask_q   <= sel_wdata;
         rr_q     <= !grant_id;
      end
   end

   // Read latency counter and captured readdata
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         cap_q <= '0;
      end else begin
         if (state == S_ISSUE) begin
            cnt_q <= LAT_INIT;
         end else if (state == S_WAIT) begin
            cnt_q <= cnt_q - 2'd1;
         end
         if (capture) begin
            cap_q <= rd_sel;
         end
      end
   end

   // Per-port address/writedata registers; they hold while the bus is idle.
   // Set/clear writedata is merged at the capture edge so it is ready in WRITE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_s1_address   <= '0;
         led_s1_writedata <= '0;
         tp_s1_address    <= '0;
         tp_s1_writedata  <= '0;
      end else begin
         if (grant_any && !sel_target) begin
            led_s1_address <= sel_addr;
            if (sel_op == OP_WR) begin
               led_s1_writedata <= sel_wdata;
            end
         end
         if (grant_any && sel_target) begin
            tp_s1_address <= sel_addr;
            if (sel_op == OP_WR) begin
               tp_s1_writedata <= sel_wdata;
            end
         end
         if (capture && (op_q != OP_RD)) begin
            if (tgt_q) begin
               tp_s1_writedata <= merged;
            end else begin
               led_s1_writedata <= merged;
            end
         end
      end
   end

   // Per-requester response data, held until that requester's next response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req0_rdata <= '0;
         req1_rdata <= '0;
      end else if (resp_load) begin
         if (gnt_id_q) begin
            req1_rdata <= resp_data;
         end else begin
            req0_rdata <= resp_data;
         end
      end
   end

endmodule

// File: tb/tb_gpio_access_arbiter.sv
// Directed bench for gpio_access_arbiter with a response scoreboard.

module tb_gpio_access_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 3;

   logic          clk = 1'b0;
   logic          rst;

   logic          req0_valid, req0_ready, req0_target, req0_rvalid;
   logic [1:0]    req0_op;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata, req0_rdata;
   logic          req1_valid, req1_ready, req1_target, req1_rvalid;
   logic [1:0]    req1_op;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata, req1_rdata;

   logic [AW-1:0] led_s1_address, tp_s1_address;
   logic          led_s1_write_n, tp_s1_write_n;
   logic [DW-1:0] led_s1_writedata, tp_s1_writedata;
   logic          led_s1_chipselect, tp_s1_chipselect;
   logic [DW-1:0] led_s1_readdata, tp_s1_readdata;
   logic          busy;

   always #5 clk = ~clk;

   gpio_access_arbiter #(.RD_LAT(1), .DW(DW), .AW(AW)) dut (
      .pheriphal_clk_clk     (clk),
      .pheriphal_reset_reset (rst),
      .req0_valid            (req0_valid),
      .req0_ready            (req0_ready),
      .req0_target           (req0_target),
      .req0_op               (req0_op),
      .req0_addr             (req0_addr),
      .req0_wdata            (req0_wdata),
      .req0_rvalid           (req0_rvalid),
      .req0_rdata            (req0_rdata),
      .req1_valid            (req1_valid),
      .req1_ready            (req1_ready),
      .req1_target           (req1_target),
      .req1_op               (req1_op),
      .req1_addr             (req1_addr),
      .req1_wdata            (req1_wdata),
      .req1_rvalid           (req1_rvalid),
      .req1_rdata            (req1_rdata),
      .led_s1_address        (led_s1_address),
      .led_s1_write_n        (led_s1_write_n),
      .led_s1_writedata      (led_s1_writedata),
      .led_s1_chipselect     (led_s1_chipselect),
      .led_s1_readdata       (led_s1_readdata),
      .tp_s1_address         (tp_s1_address),
      .tp_s1_write_n         (tp_s1_write_n),
      .tp_s1_writedata       (tp_s1_writedata),
      .tp_s1_chipselect      (tp_s1_chipselect),
      .tp_s1_readdata        (tp_s1_readdata),
      .busy                  (busy)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];

   int led_cs_cnt = 0, tp_cs_cnt = 0, led_wr_cnt = 0, tp_wr_cnt = 0;
   int rv0_cnt = 0, rv1_cnt = 0;
   logic pend0 = 1'b0, pend1 = 1'b0;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic tgt, input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req0_target = tgt; req0_op = op; req0_addr = a; req0_wdata = d; req0_valid = 1'b1;
   endtask

   task automatic drive1(input logic tgt, input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req1_target = tgt; req1_op = op; req1_addr = a; req1_wdata = d; req1_valid = 1'b1;
   endtask

   // Scoreboard consumer, strobe counters and request-hold protocol check
   always @(negedge clk) begin
      logic [DW-1:0] e;
      if (!rst) begin
         if (led_s1_chipselect) led_cs_cnt++;
         if (tp_s1_chipselect)  tp_cs_cnt++;
         if (led_s1_chipselect && !led_s1_write_n) led_wr_cnt++;
         if (tp_s1_chipselect  && !tp_s1_write_n)  tp_wr_cnt++;
         if (req0_rvalid) begin
            rv0_cnt++;
            if (q0.size() == 0) check("rvalid0_unexpected", req0_rvalid, 1'b0);
            else begin e = q0.pop_front(); check("rdata0", req0_rdata, e); end
         end
         if (req1_rvalid) begin
            rv1_cnt++;
            if (q1.size() == 0) check("rvalid1_unexpected", req1_rvalid, 1'b0);
            else begin e = q1.pop_front(); check("rdata1", req1_rdata, e); end
         end
         if (pend0) check("req0_valid_hold", req0_valid, 1'b1);
         if (pend1) check("req1_valid_hold", req1_valid, 1'b1);
         pend0 = req0_valid && !req0_ready;
         pend1 = req1_valid && !req1_ready;
      end else begin
         pend0 = 1'b0;
         pend1 = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s_led, s_tp, s_lw, s_tw, s_rv0, s_rv1;
      int g0, g1, both;
      int grants[$];
      logic got1;
      int exp_order[4];

      rst = 1'b1;
      req0_valid = 0; req0_target = 0; req0_op = 0; req0_addr = 0; req0_wdata = 0;
      req1_valid = 0; req1_target = 0; req1_op = 0; req1_addr = 0; req1_wdata = 0;
      led_s1_readdata = '0; tp_s1_readdata = '0;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready0", req0_ready, 0);
      check("rst_rvalid1", req1_rvalid, 0);
      check("rst_rdata0", req0_rdata, 0);
      check("rst_led_cs", led_s1_chipselect, 0);
      check("rst_tp_cs", tp_s1_chipselect, 0);
      check("rst_led_wn", led_s1_write_n, 1);
      check("rst_tp_wn", tp_s1_write_n, 1);
      check("rst_led_addr", led_s1_address, 0);
      check("rst_tp_wd", tp_s1_writedata, 0);
      check("rst_busy", busy, 0);
      tick(); rst = 1'b0;

      // Write: req0 -> LED addr 0, data A5
      tick();
      drive0(1'b0, 2'b01, 3'd0, 32'h0000_00A5); q0.push_back('0);
      s_led = led_cs_cnt; s_tp = tp_cs_cnt;
      @(negedge clk);
      check("wr_ready0", req0_ready, 1);
      check("wr_ready1", req1_ready, 0);
      tick(); req0_valid = 1'b0;
      @(negedge clk);
      check("wr_t1_led_cs", led_s1_chipselect, 1);
      check("wr_t1_led_wn", led_s1_write_n, 0);
      check("wr_t1_led_addr", led_s1_address, 0);
      check("wr_t1_led_wd", led_s1_writedata, 32'hA5);
      check("wr_t1_tp_cs", tp_s1_chipselect, 0);
      tick(); @(negedge clk);
      check("wr_t2_rvalid0", req0_rvalid, 1);
      check("wr_t2_led_cs", led_s1_chipselect, 0);
      tick(); @(negedge clk);
      check("wr_idle", busy, 0);
      check("wr_led_cs_cycles", led_cs_cnt - s_led, 1);
      check("wr_tp_cs_cycles", tp_cs_cnt - s_tp, 0);

      // Read: req1 <- TP addr 0, readdata 5A valid only at T2
      tick();
      tp_s1_readdata = 32'hDEAD_BEEF;
      drive1(1'b1, 2'b00, 3'd0, 32'hFFFF_FFFF); q1.push_back(32'h5A);
      s_tw = tp_wr_cnt;
      @(negedge clk);
      check("rd_ready1", req1_ready, 1);
      check("rd_ready0", req0_ready, 0);
      tick(); req1_valid = 1'b0;
      @(negedge clk);
      check("rd_t1_tp_cs", tp_s1_chipselect, 1);
      check("rd_t1_tp_wn", tp_s1_write_n, 1);
      check("rd_t1_led_cs", led_s1_chipselect, 0);
      tick(); tp_s1_readdata = 32'h5A;
      @(negedge clk);
      check("rd_t2_tp_cs", tp_s1_chipselect, 0);
      check("rd_t2_rvalid1", req1_rvalid, 0);
      tick(); tp_s1_readdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("rd_t3_rvalid1", req1_rvalid, 1);
      tick(); @(negedge clk);
      check("rd_idle", busy, 0);
      check("rd_rdata1_hold", req1_rdata, 32'h5A);
      check("rd_no_write", tp_wr_cnt - s_tw, 0);

      // Set-bits: req0 on LED addr 3, mask 0F, readdata F0 at T2
      tick();
      led_s1_readdata = 32'h1234_5678;
      drive0(1'b0, 2'b10, 3'd3, 32'h0F); q0.push_back(32'hF0);
      s_led = led_cs_cnt; s_lw = led_wr_cnt; s_tp = tp_cs_cnt;
      @(negedge clk);
      check("set_ready0", req0_ready, 1);
      tick(); req0_valid = 1'b0;
      @(negedge clk);
      check("set_t1_led_cs", led_s1_chipselect, 1);
      check("set_t1_led_wn", led_s1_write_n, 1);
      check("set_t1_led_addr", led_s1_address, 3);
      tick(); led_s1_readdata = 32'hF0;
      @(negedge clk);
      check("set_t2_led_cs", led_s1_chipselect, 0);
      check("set_t2_busy", busy, 1);
      tick(); led_s1_readdata = 32'h1234_5678;
      @(negedge clk);
      check("set_t3_led_cs", led_s1_chipselect, 1);
      check("set_t3_led_wn", led_s1_write_n, 0);
      check("set_t3_led_wd", led_s1_writedata, 32'hFF);
      check("set_t3_led_addr", led_s1_address, 3);
      check("set_t3_rvalid0", req0_rvalid, 0);
      tick(); @(negedge clk);
      check("set_t4_rvalid0", req0_rvalid, 1);
      check("set_t4_led_cs", led_s1_chipselect, 0);
      tick(); @(negedge clk);
      check("set_idle", busy, 0);
      check("set_led_cs_cycles", led_cs_cnt - s_led, 2);
      check("set_led_wr_cycles", led_wr_cnt - s_lw, 1);
      check("set_tp_cs_cycles", tp_cs_cnt - s_tp, 0);

      // Clear-bits: req1 on TP addr 5, mask 81, readdata FF at T2
      tick();
      tp_s1_readdata = 32'hA5A5_A5A5;
      drive1(1'b1, 2'b11, 3'd5, 32'h81); q1.push_back(32'hFF);
      @(negedge clk);
      check("clr_ready1", req1_ready, 1);
      tick(); req1_valid = 1'b0;
      @(negedge clk);
      check("clr_t1_tp_addr", tp_s1_address, 5);
      tick(); tp_s1_readdata = 32'hFF;
      @(negedge clk);
      tick(); tp_s1_readdata = 32'hA5A5_A5A5;
      @(negedge clk);
      check("clr_t3_tp_cs", tp_s1_chipselect, 1);
      check("clr_t3_tp_wn", tp_s1_write_n, 0);
      check("clr_t3_tp_wd", tp_s1_writedata, 32'h7E);
      tick(); @(negedge clk);
      check("clr_t4_rvalid1", req1_rvalid, 1);
      tick(); @(negedge clk);
      check("clr_idle", busy, 0);

      // Both requesters hold valid for four writes: grants alternate
      tick();
      drive0(1'b0, 2'b01, 3'd1, 32'h11);
      drive1(1'b1, 2'b01, 3'd2, 32'h22);
      q0.push_back('0); q0.push_back('0); q1.push_back('0); q1.push_back('0);
      s_rv0 = rv0_cnt; s_rv1 = rv1_cnt;
      g0 = 0; g1 = 0; both = 0;
      for (int c = 0; c < 40 && (g0 < 2 || g1 < 2); c++) begin
         @(negedge clk);
         if (req0_ready && req1_ready) both++;
         if (req0_ready) begin grants.push_back(0); g0++; end
         if (req1_ready) begin grants.push_back(1); g1++; end
         tick();
         if (g0 >= 2) req0_valid = 1'b0;
         if (g1 >= 2) req1_valid = 1'b0;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!busy) break;
      end
      exp_order = '{0, 1, 0, 1};
      check("rr_grant_count", grants.size(), 4);
      check("rr_dual_ready", both, 0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rr_grant%0d", i), (i < grants.size()) ? grants[i] : 99, exp_order[i]);
      end
      check("rr_drain", busy, 0);
      check("rr_rvalid0_count", rv0_cnt - s_rv0, 2);
      check("rr_rvalid1_count", rv1_cnt - s_rv1, 2);
      check("rr_led_wd", led_s1_writedata, 32'h11);
      check("rr_tp_wd", tp_s1_writedata, 32'h22);

      // Reset during WAIT of a set-bits op by req0 (pointer then favours req1)
      tick();
      led_s1_readdata = 32'hF0;
      drive0(1'b0, 2'b10, 3'd4, 32'h0F);
      s_lw = led_wr_cnt; s_rv0 = rv0_cnt;
      @(negedge clk);
      check("rwait_ready0", req0_ready, 1);
      tick(); req0_valid = 1'b0;
      @(negedge clk);
      check("rwait_read_strobe", led_s1_chipselect, 1);
      tick(); #1;
      check("rwait_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("rwait_led_cs", led_s1_chipselect, 0);
      check("rwait_led_wn", led_s1_write_n, 1);
      check("rwait_busy_clr", busy, 0);
      check("rwait_led_addr", led_s1_address, 0);
      check("rwait_led_wd", led_s1_writedata, 0);
      repeat (2) tick();
      rst = 1'b0;
      repeat (3) tick();
      check("rwait_no_write", led_wr_cnt - s_lw, 0);
      check("rwait_no_rvalid", rv0_cnt - s_rv0, 0);

      // First simultaneous request after reset goes to req0
      tp_s1_readdata = 32'h3C;
      drive0(1'b1, 2'b00, 3'd0, 32'h0);
      drive1(1'b1, 2'b00, 3'd1, 32'h0);
      q0.push_back(32'h3C); q1.push_back(32'h3C);
      @(negedge clk);
      check("post_rst_ready0", req0_ready, 1);
      check("post_rst_ready1", req1_ready, 0);
      tick(); req0_valid = 1'b0;
      got1 = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (req1_ready) begin got1 = 1'b1; break; end
      end
      check("post_rst_req1_granted", got1, 1);
      tick(); req1_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check("post_rst_drain", busy, 0);
      check("q0_empty", q0.size(), 0);
      check("q1_empty", q1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/gpio_access_arbiter.md
Name: gpio_access_arbiter

Overview:
- Avalon-MM master that shares the LED and test-point PIO s1 slave ports between two on-chip requesters, for example the coil-driver sequencer and the status/debug logic.
- Uses round-robin arbitration and serialises one transaction at a time.
- Provides atomic bit-set and bit-clear operations as read-modify-write, so requesters never race on shared PIO data registers.
- Sits between the requesters and the subsystemA PIO s1 ports.

Parameters:
- RD_LAT, 1, PIO s1 read latency in cycles; legal range 1..3.
- DW, 32, data width of the s1 readdata and writedata buses.
- AW, 3, address width of the s1 address bus.

Ports:
- pheriphal_clk_clk  in  1  the single clock.
- pheriphal_reset_reset  in  1  asynchronous, active-high reset.
- reqN_valid (N=0,1)  in  1  request pending; valid and all request fields are held stable until reqN_ready.
- reqN_ready  out  1  one-cycle pulse that accepts the request.
- reqN_target  in  1  0 = LED PIO, 1 = TP PIO.
- reqN_op  in  2  00 read, 01 write, 10 set-bits, 11 clear-bits.
- reqN_addr  in  AW  PIO register address.
- reqN_wdata  in  DW  write data, or bit mask for set/clear ops.
- reqN_rvalid  out  1  one-cycle completion pulse.
- reqN_rdata  out  DW  read data, or old register value for set/clear ops.
- led_s1_address / tp_s1_address  out  AW  address to the PIO.
- led_s1_write_n / tp_s1_write_n  out  1  active-low write strobe.
- led_s1_writedata / tp_s1_writedata  out  DW  write data.
- led_s1_chipselect / tp_s1_chipselect  out  1  chip select.
- led_s1_readdata / tp_s1_readdata  in  DW  read data from the PIO.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - All outputs are 0, except both s1 write_n outputs, which are 1.
  - FSM in IDLE; round-robin pointer favours requester 0.
  - Internal latches are cleared.
- Reset is asynchronous: asserting it in any state abandons the transaction in flight immediately. No rvalid is issued and no further chipselect is driven.
- Idle bus: chipselect=0 and write_n=1 on both ports. Address and writedata hold their last driven values.
- Only the selected target's chipselect is ever asserted. chipselect is high for exactly one cycle per bus access.
- Arbitration happens in IDLE:
  - If only one valid is high, grant that requester.
  - If both are high, grant the requester not granted last.
  - The round-robin pointer updates only on a grant.
  - reqN_ready pulses in the grant cycle, and the request is latched in that same cycle.
- FSM states:
  - IDLE: on grant, go to ISSUE.
  - ISSUE: chipselect=1 and address=latched addr.
    - op=01: write_n=0, writedata=wdata, then go to RESP.
    - Other ops: write_n=1, load the latency counter with RD_LAT, then go to WAIT.
  - WAIT: the counter decrements each cycle. In the cycle the counter reaches 1, capture the target readdata into the rdata latch.
    - op=00: go to RESP.
    - op=10/11: go to WRITE.
  - WRITE: chipselect=1, write_n=0, same address.
    - writedata = captured value | mask for op 10.
    - writedata = captured value & ~mask for op 11.
    - Then go to RESP.
  - RESP: pulse rvalid of the granted requester for 1 cycle.
    - rdata = captured value for ops 00/10/11; 0 for op 01.
    - Then go to IDLE.
- rdata holds its value after the rvalid pulse until the next response to the same requester.
- Latency from the grant cycle T0:
  - Write: chipselect at T1, rvalid at T2.
  - Read: chipselect at T1, capture at T1+RD_LAT, rvalid at T2+RD_LAT.
  - Set/clear: read phase as above, write strobe at T2+RD_LAT, rvalid at T3+RD_LAT.
- Throughput: the next grant happens no earlier than the cycle after RESP.
- A requester may re-assert valid in the same cycle as its rvalid. That request is arbitrated in the following IDLE cycle.
- Masks are applied bitwise across the full DW width. There is no width extension and no arithmetic.
- A valid that drops before ready is a protocol violation; the bench flags it with an assertion.

Test Plan:
- req0 writes LED addr 0, data 0x000000A5 -> led_s1_chipselect=1 with write_n=0 at T1, rvalid0 at T2, tp_s1_chipselect never asserted.
- req1 reads TP addr 0 with RD_LAT=1 and tp_s1_readdata=0x5A at T2 -> rvalid1 at T3 with rdata1=0x5A.
- req0 set-bits on LED with mask 0x0F while readdata=0xF0 -> read strobe at T1, write strobe at T3 with writedata=0xFF, rvalid0 at T4 with rdata0=0xF0.
- Clear-bits with mask 0x81 while readdata=0xFF -> writedata=0x7E.
- Both requesters hold valid continuously for 4 transactions -> grants alternate 0,1,0,1, with exactly one ready pulse per grant.
- Reset asserted during WAIT of a set-bits op -> all chipselects drop immediately and no write strobe or rvalid occurs. After release, the first simultaneous request is granted to req0.
